// File: rtl/mat_mult_pkg.sv
// Shared types and helpers for the matrix-multiply sequencer.
// Provides the state enum and clog2m1(), which returns the clog2 of a value but never less than 1.
package mat_mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    MAC,
    WR,
    DONE
  } state_t;

  function automatic int clog2m1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mat_mult_idx_counter.sv
// Nested i/j/k element counter for the MAC walk.
// Ports: clk, reset (async, active-high), clr (sync), inc_k, inc_ij; outputs i/j/k and their last flags.
module mat_mult_idx_counter
  import mat_mult_pkg::*;
#(
  parameter int M = 3,
  parameter int K = 4,
  parameter int N = 3,
  localparam int IW = clog2m1(M),
  localparam int JW = clog2m1(N),
  localparam int KW = clog2m1(K)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc_k,
  input  logic          inc_ij,
  output logic [IW-1:0] i,
  output logic [JW-1:0] j,
  output logic [KW-1:0] k,
  output logic          i_last,
  output logic          j_last,
  output logic          k_last
);

  assign i_last = (i == IW'(M - 1));
  assign j_last = (j == JW'(N - 1));
  assign k_last = (k == KW'(K - 1));

  // k wraps without carrying: the WR cycle advances (i,j) on its own,
  // so out_idx still sees the element that was just accumulated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (clr) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      if (inc_k)
        k <= k_last ? '0 : k + 1'b1;
      if (inc_ij) begin
        if (j_last) begin
          j <= '0;
          i <= i_last ? '0 : i + 1'b1;
        end else begin
          j <= j + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mat_mult_sequencer.sv
// Control sequencer for C[MxN] = A[MxK] * B[KxN]: clear, operand load, K MAC cycles plus write-back per element.
// Ports: clk, reset (async, high), start, abort, [stall when MATMUL_SEQ_STALL_EN]; strobes, index buses, busy, done.
module mat_mult_sequencer
  import mat_mult_pkg::*;
#(
  parameter int M = 3,
  parameter int K = 4,
  parameter int N = 3,
  localparam int LOAD_WORDS = M * K + K * N,
  localparam int LD_W = clog2m1(LOAD_WORDS),
  localparam int OUT_W = clog2m1(max3(M * N, M * K, K * N)),
  localparam int KW = clog2m1(K)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
`ifdef MATMUL_SEQ_STALL_EN
  input  logic             stall,
`endif
  output logic             res_clr,
  output logic             ld_en,
  output logic [LD_W-1:0]  ld_sel,
  output logic             mac_en,
  output logic             mac_clr,
  output logic [OUT_W-1:0] a_sel,
  output logic [OUT_W-1:0] b_sel,
  output logic             out_wr,
  output logic [OUT_W-1:0] out_idx,
  output logic             busy,
  output logic             done
);

  localparam int IW = clog2m1(M);
  localparam int JW = clog2m1(N);

  state_t          state;
  logic [LD_W-1:0] ld_cnt;
  logic [IW-1:0]   i;
  logic [JW-1:0]   j;
  logic [KW-1:0]   k;
  logic            i_last;
  logic            j_last;
  logic            k_last;
  logic            stl;

`ifdef MATMUL_SEQ_STALL_EN
  assign stl = stall & (state == LOAD || state == MAC || state == WR);
`else
  assign stl = 1'b0;
`endif

  mat_mult_idx_counter #(
    .M(M),
    .K(K),
    .N(N)
  ) u_idx (
    .clk   (clk),
    .reset (reset),
    .clr   (abort || state == IDLE),
    .inc_k (state == MAC && !stl),
    .inc_ij(state == WR && !stl),
    .i     (i),
    .j     (j),
    .k     (k),
    .i_last(i_last),
    .j_last(j_last),
    .k_last(k_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ld_cnt <= '0;
    end else if (abort) begin
      state  <= IDLE;
      ld_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) state <= CLR;
        CLR: begin
          state  <= LOAD;
          ld_cnt <= '0;
        end
        LOAD: if (!stl) begin
          if (ld_cnt == LD_W'(LOAD_WORDS - 1)) begin
            state  <= MAC;
            ld_cnt <= '0;
          end else begin
            ld_cnt <= ld_cnt + 1'b1;
          end
        end
        MAC: if (!stl && k_last) state <= WR;
        WR: if (!stl) state <= (i_last && j_last) ? DONE : MAC;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    res_clr = 1'b0;
    ld_en   = 1'b0;
    ld_sel  = '0;
    mac_en  = 1'b0;
    mac_clr = 1'b0;
    a_sel   = '0;
    b_sel   = '0;
    out_wr  = 1'b0;
    out_idx = '0;
    done    = 1'b0;
    busy    = (state != IDLE);
    unique case (state)
      CLR: res_clr = 1'b1;
      LOAD: begin
        ld_en  = !stl;
        ld_sel = ld_cnt;
      end
      MAC: begin
        mac_en  = !stl;
        mac_clr = !stl && (k == '0);
        a_sel   = OUT_W'(i) * OUT_W'(K) + OUT_W'(k);
        b_sel   = OUT_W'(k) * OUT_W'(N) + OUT_W'(j);
      end
      WR: begin
        out_wr  = !stl;
        out_idx = OUT_W'(i) * OUT_W'(N) + OUT_W'(j);
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mat_mult_sequencer.sv
// Scoreboard bench for mat_mult_sequencer: a 3x4x3 instance and a 1x1x1 instance.
// Stimulus pushes expected strobe events; per-instance monitors pop and compare on every strobe cycle.
module tb_mat_mult_sequencer;
  import mat_mult_pkg::*;

  localparam int LD0 = clog2m1(24);
  localparam int OW0 = clog2m1(12);
  localparam int LD1 = clog2m1(2);
  localparam int OW1 = clog2m1(1);

  typedef struct packed {
    logic [31:0] cyc;
    logic        rc;
    logic        le;
    logic [7:0]  ls;
    logic        me;
    logic        mc;
    logic [7:0]  as;
    logic [7:0]  bs;
    logic        ow;
    logic [7:0]  oi;
    logic        dn;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start0 = 1'b0, abort0 = 1'b0, stall0 = 1'b0;
  logic start1 = 1'b0, abort1 = 1'b0, stall1 = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  ev_t  q0[$];
  ev_t  q1[$];

  logic           res_clr0, ld_en0, mac_en0, mac_clr0, out_wr0, busy0, done0;
  logic [LD0-1:0] ld_sel0;
  logic [OW0-1:0] a_sel0, b_sel0, out_idx0;
  logic           res_clr1, ld_en1, mac_en1, mac_clr1, out_wr1, busy1, done1;
  logic [LD1-1:0] ld_sel1;
  logic [OW1-1:0] a_sel1, b_sel1, out_idx1;

  mat_mult_sequencer #(.M(3), .K(4), .N(3)) u0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort0),
`ifdef MATMUL_SEQ_STALL_EN
    .stall(stall0),
`endif
    .res_clr(res_clr0), .ld_en(ld_en0), .ld_sel(ld_sel0),
    .mac_en(mac_en0), .mac_clr(mac_clr0), .a_sel(a_sel0), .b_sel(b_sel0),
    .out_wr(out_wr0), .out_idx(out_idx0), .busy(busy0), .done(done0)
  );

  mat_mult_sequencer #(.M(1), .K(1), .N(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
`ifdef MATMUL_SEQ_STALL_EN
    .stall(stall1),
`endif
    .res_clr(res_clr1), .ld_en(ld_en1), .ld_sel(ld_sel1),
    .mac_en(mac_en1), .mac_clr(mac_clr1), .a_sel(a_sel1), .b_sel(b_sel1),
    .out_wr(out_wr1), .out_idx(out_idx1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(
    input logic rc, input logic le, input logic [7:0] ls,
    input logic me, input logic mc, input logic [7:0] as, input logic [7:0] bs,
    input logic ow, input logic [7:0] oi, input logic dn);
    ev_t e;
    e.cyc = '0;
    e.rc = rc; e.le = le; e.ls = ls;
    e.me = me; e.mc = mc; e.as = as; e.bs = bs;
    e.ow = ow; e.oi = oi; e.dn = dn;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h at cyc %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic put(input int w, input int b, input int c, input int lim,
                     input int sh_at, input int sh_n, input ev_t e);
    ev_t x;
    x = e;
    if (c <= lim) begin
      x.cyc = b + c + ((c >= sh_at) ? sh_n : 0);
      if (w == 0) q0.push_back(x);
      else q1.push_back(x);
    end
  endtask

  // Expected strobe events of one job; cycle 1 is the cycle after the edge sampling start.
  task automatic push_run(input int w, input int b, input int m, input int k, input int n,
                          input int lim, input int sh_at, input int sh_n);
    int c = 1;
    put(w, b, c, lim, sh_at, sh_n, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    c++;
    for (int x = 0; x < m * k + k * n; x++) begin
      put(w, b, c, lim, sh_at, sh_n, mk(0, 1, 8'(x), 0, 0, 0, 0, 0, 0, 0));
      c++;
    end
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < n; j++) begin
        for (int kk = 0; kk < k; kk++) begin
          put(w, b, c, lim, sh_at, sh_n,
              mk(0, 0, 0, 1, (kk == 0), 8'(i * k + kk), 8'(kk * n + j), 0, 0, 0));
          c++;
        end
        put(w, b, c, lim, sh_at, sh_n, mk(0, 0, 0, 0, 0, 0, 0, 1, 8'(i * n + j), 0));
        c++;
      end
    end
    put(w, b, c, lim, sh_at, sh_n, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
  endtask

  task automatic go(input int w, input int lim, input int sh_at, input int sh_n, output int b);
    @(negedge clk);
    b = cyc;
    if (w == 0) push_run(0, b, 3, 4, 3, lim, sh_at, sh_n);
    else push_run(1, b, 1, 1, 1, lim, sh_at, sh_n);
    if (w == 0) start0 = 1'b1;
    else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk_empty(input string nm, input int w);
    chk(nm, 64'((w == 0) ? q0.size() : q1.size()), 64'd0);
    if (w == 0) q0.delete();
    else q1.delete();
  endtask

  always @(negedge clk) begin
    ev_t a, e;
    if (res_clr0 | ld_en0 | mac_en0 | out_wr0 | done0) begin
      a = mk(res_clr0, ld_en0, 8'(ld_sel0), mac_en0, mac_clr0,
             8'(a_sel0), 8'(b_sel0), out_wr0, 8'(out_idx0), done0);
      a.cyc = cyc;
      n_vec++;
      if (q0.size() == 0) begin
        n_bad++;
        $display("FAIL u0_unexpected got %h", a);
      end else begin
        e = q0.pop_front();
        if (a !== e) begin
          n_bad++;
          $display("FAIL u0_event got %h want %h", a, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    ev_t a, e;
    if (res_clr1 | ld_en1 | mac_en1 | out_wr1 | done1) begin
      a = mk(res_clr1, ld_en1, 8'(ld_sel1), mac_en1, mac_clr1,
             8'(a_sel1), 8'(b_sel1), out_wr1, 8'(out_idx1), done1);
      a.cyc = cyc;
      n_vec++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL u1_unexpected got %h", a);
      end else begin
        e = q1.pop_front();
        if (a !== e) begin
          n_bad++;
          $display("FAIL u1_event got %h want %h", a, e);
        end
      end
    end
  end

  function automatic logic [63:0] outs0();
    return 64'({res_clr0, ld_en0, ld_sel0, mac_en0, mac_clr0, a_sel0, b_sel0,
                out_wr0, out_idx0, busy0, done0});
  endfunction

  function automatic logic [63:0] outs1();
    return 64'({res_clr1, ld_en1, ld_sel1, mac_en1, mac_clr1, a_sel1, b_sel1,
                out_wr1, out_idx1, busy1, done1});
  endfunction

  initial begin
    int b;
    repeat (3) @(negedge clk);
    chk("reset_u0", outs0(), 64'd0);
    chk("reset_u1", outs1(), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // full default job, including element (1,2)
    go(0, 1000, 1000, 0, b);
    wait_cyc(b + 72);
    chk("idle_after_done", 64'(busy0), 64'd0);
    chk_empty("full_run_left", 0);

    // 1x1x1 instance
    go(1, 1000, 1000, 0, b);
    wait_cyc(b + 7);
    chk("u1_idle_after_done", 64'(busy1), 64'd0);
    chk_empty("u1_run_left", 1);

    // abort during cycle 30
    go(0, 30, 1000, 0, b);
    wait_cyc(b + 30);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("abort_busy", 64'(busy0), 64'd0);
    wait_cyc(b + 80);
    chk_empty("abort_left", 0);
    go(0, 1000, 1000, 0, b);
    wait_cyc(b + 72);
    chk("rerun_idle", 64'(busy0), 64'd0);
    chk_empty("rerun_left", 0);

    // start and abort together in IDLE
    @(negedge clk);
    start0 = 1'b1;
    abort0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    abort0 = 1'b0;
    chk("start_abort_idle", 64'(busy0), 64'd0);

    // asynchronous reset mid-LOAD
    go(0, 10, 1000, 0, b);
    wait_cyc(b + 10);
    #1 reset = 1'b1;
    #1 chk("async_reset", outs0(), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    chk_empty("reset_left", 0);
    @(negedge clk);

    // start during MAC is ignored
    go(0, 1000, 1000, 0, b);
    wait_cyc(b + 40);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_cyc(b + 71);
    chk("done_c71", 64'(done0), 64'd1);
    wait_cyc(b + 72);
    chk("ignore_start_idle", 64'(busy0), 64'd0);
    chk_empty("ignore_start_left", 0);

`ifdef MATMUL_SEQ_STALL_EN
    // three stalled cycles during element (0,0), k=2
    go(0, 1000, 28, 3, b);
    wait_cyc(b + 27);
    @(posedge clk);
    #1 stall0 = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("stall_strobes", 64'({ld_en0, mac_en0, mac_clr0, out_wr0}), 64'd0);
      chk("stall_a_sel", 64'(a_sel0), 64'd2);
      chk("stall_b_sel", 64'(b_sel0), 64'd6);
      @(posedge clk);
    end
    #1 stall0 = 1'b0;
    wait_cyc(b + 75);
    chk("stall_idle", 64'(busy0), 64'd0);
    chk_empty("stall_left", 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
